// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the wait-state data-memory responder.
// Optional feature macro used by this slice: DMEM_ALIGN_CHECK_EN.
package dmem_responder_pkg;

  localparam int unsigned MACHINE_WIDTH_DEF = 32;
  localparam int unsigned MEMORY_DEPTH_DEF  = 1024;
  localparam int unsigned WAIT_CYCLES_DEF   = 2;
  localparam int unsigned WAIT_CYCLES_MAX   = 15;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write, combinational read, no reset.
module dmem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a word on a qualified write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: answers CPU data-port requests after a fixed
// number of wait states and signals completion with a one-cycle dm_ready.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned accesses pulse
// dm_error and are suppressed); when undefined dm_error is constant 0.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned MACHINE_WIDTH = MACHINE_WIDTH_DEF,
  parameter int unsigned MEMORY_DEPTH  = MEMORY_DEPTH_DEF,
  parameter int unsigned WAIT_CYCLES   = WAIT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_mem_read,
  input  logic                     data_mem_write,
  input  logic [MACHINE_WIDTH-1:0] dm_address,
  input  logic [MACHINE_WIDTH-1:0] data_to_dm,
  output logic [MACHINE_WIDTH-1:0] dm_data,
  output logic                     dm_ready,
  output logic                     dm_error
);

  localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);
  localparam int unsigned WAIT_CLAMP =
    (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CLAMP);
  localparam logic [MACHINE_WIDTH-1:0] ADDR_LIMIT = MACHINE_WIDTH'(4 * MEMORY_DEPTH);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MACHINE_WIDTH-1:0] addr_q, addr_d;
  logic [MACHINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                     wr_q, wr_d;
  logic [MACHINE_WIDTH-1:0] dm_data_q, dm_data_d;
  logic                     dm_ready_q, dm_ready_d;
  logic                     dm_error_q, dm_error_d;

  logic [MACHINE_WIDTH-1:0] acc_addr;
  logic [MACHINE_WIDTH-1:0] acc_wdata;
  logic                     acc_wr;
  logic [IDX_W-1:0]         acc_idx;
  logic                     enter_done;
  logic                     in_range;
  logic                     misaligned;
  logic                     word_ok;
  logic                     mem_we;
  logic [MACHINE_WIDTH-1:0] mem_rdata;

  // Next-state, latch and output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    dm_data_d  = dm_data_q;
    dm_ready_d = 1'b0;
    dm_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_mem_write || data_mem_read) begin
          addr_d  = dm_address;
          wdata_d = data_to_dm;
          wr_d    = data_mem_write;
          if (WAIT_INIT == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // With zero wait states the access completes on the sampling edge,
    // so the live inputs stand in for the not-yet-latched copies.
    if (state_q == ST_IDLE) begin
      acc_addr  = dm_address;
      acc_wdata = data_to_dm;
      acc_wr    = data_mem_write;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wr    = wr_q;
    end

    acc_idx    = acc_addr[IDX_W+1:2];
    in_range   = acc_addr < ADDR_LIMIT;
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = acc_addr[1:0] != 2'b00;
`else
    misaligned = 1'b0;
`endif
    word_ok    = in_range && !misaligned;
    enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    mem_we     = enter_done && acc_wr && word_ok;

    if (enter_done) begin
      dm_ready_d = 1'b1;
      dm_error_d = misaligned;
      if (!acc_wr) begin
        dm_data_d = word_ok ? mem_rdata : '0;
      end
    end
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      dm_data_q  <= '0;
      dm_ready_q <= 1'b0;
      dm_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      dm_data_q  <= dm_data_d;
      dm_ready_q <= dm_ready_d;
      dm_error_q <= dm_error_d;
    end
  end

  dmem_array #(
    .WIDTH (MACHINE_WIDTH),
    .DEPTH (MEMORY_DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  assign dm_data  = dm_data_q;
  assign dm_ready = dm_ready_q;
  assign dm_error = dm_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned MW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int          WAIT  = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          data_mem_read;
  logic          data_mem_write;
  logic [MW-1:0] dm_address;
  logic [MW-1:0] data_to_dm;
  logic [MW-1:0] dm_data;
  logic          dm_ready;
  logic          dm_error;

  int asserts  = 0;
  int failures = 0;

  logic [MW-1:0] mem_m [DEPTH];
  logic [MW-1:0] exp_data_m;

  dmem_responder #(
    .MACHINE_WIDTH (MW),
    .MEMORY_DEPTH  (DEPTH),
    .WAIT_CYCLES   (WAIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_mem_read  (data_mem_read),
    .data_mem_write (data_mem_write),
    .dm_address     (dm_address),
    .data_to_dm     (data_to_dm),
    .dm_data        (dm_data),
    .dm_ready       (dm_ready),
    .dm_error       (dm_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference behaviour: one access applied to the word array / read register
  function automatic void model_access(input logic r, input logic w,
                                       input logic [MW-1:0] a, input logic [MW-1:0] d,
                                       output logic [MW-1:0] exp_rd, output logic exp_err);
    bit mis;
    bit inr;
    int idx;
    mis     = ALIGN_EN && ((a % 4) != 0);
    inr     = a < 32'(4 * DEPTH);
    idx     = int'((a / 4) % DEPTH);
    exp_err = mis;
    if (w) begin
      if (inr && !mis) mem_m[idx] = d;
    end else if (r) begin
      exp_data_m = (inr && !mis) ? mem_m[idx] : '0;
    end
    exp_rd = exp_data_m;
  endfunction

  // Drive one request, hold it until dm_ready, then drop it
  task automatic access(input logic r, input logic w, input logic [MW-1:0] a,
                        input logic [MW-1:0] d, output int lat, output logic [MW-1:0] rdv,
                        output logic err, output logic rdy_after);
    @(negedge clk);
    data_mem_read  = r;
    data_mem_write = w;
    dm_address     = a;
    data_to_dm     = d;
    lat = -1; rdv = '0; err = 1'b0; rdy_after = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dm_ready) begin
        lat = i; rdv = dm_data; err = dm_error;
        break;
      end
    end
    data_mem_read  = 1'b0;
    data_mem_write = 1'b0;
    @(posedge clk); #1;
    rdy_after = dm_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_mem_read = 1'b0; data_mem_write = 1'b0;
    dm_address = '0; data_to_dm = '0;
    exp_data_m = '0;
    repeat (3) @(posedge clk);
    #1;
    asserts++; if (dm_data !== '0) begin failures++; $display("FAIL reset_dm_data: got %h expected 0", dm_data); end
    asserts++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL reset_dm_ready: got %b expected 0", dm_ready); end
    asserts++; if (dm_error !== 1'b0) begin failures++; $display("FAIL reset_dm_error: got %b expected 0", dm_error); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    asserts++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL post_reset_ready: got %b expected 0", dm_ready); end
  endtask

  task automatic test_write_read();
    int lat; logic [MW-1:0] rdv, er; logic err, ra, e;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rdv, err, ra);
    model_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, er, e);
    asserts++; if (lat != WAIT) begin failures++; $display("FAIL wr_latency: got %0d expected %0d", lat, WAIT); end
    asserts++; if (ra !== 1'b0) begin failures++; $display("FAIL wr_pulse_width: ready still %b expected 0", ra); end
    asserts++; if (rdv !== er) begin failures++; $display("FAIL wr_dm_data_held: got %h expected %h", rdv, er); end
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h10, 32'h0, er, e);
    asserts++; if (lat != WAIT) begin failures++; $display("FAIL rd_latency: got %0d expected %0d", lat, WAIT); end
    asserts++; if (rdv !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data_0x10: got %h expected deadbeef", rdv); end
  endtask

  task automatic test_read_write_both();
    int lat; logic [MW-1:0] rdv, er; logic err, ra, e;
    access(1'b1, 1'b1, 32'h20, 32'h12345678, lat, rdv, err, ra);
    model_access(1'b1, 1'b1, 32'h20, 32'h12345678, er, e);
    asserts++; if (rdv !== er) begin failures++; $display("FAIL both_dm_data_kept: got %h expected %h", rdv, er); end
    access(1'b1, 1'b0, 32'h20, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h20, 32'h0, er, e);
    asserts++; if (rdv !== 32'h12345678) begin failures++; $display("FAIL both_write_won: got %h expected 12345678", rdv); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [MW-1:0] rdv, er; logic err, ra, e;
    access(1'b0, 1'b1, 32'h0, 32'h0BADF00D, lat, rdv, err, ra);
    model_access(1'b0, 1'b1, 32'h0, 32'h0BADF00D, er, e);
    access(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, er, e);
    asserts++; if (lat != WAIT) begin failures++; $display("FAIL oor_rd_ready: latency %0d expected %0d", lat, WAIT); end
    asserts++; if (rdv !== 32'h0) begin failures++; $display("FAIL oor_rd_data: got %h expected 0", rdv); end
    access(1'b0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, lat, rdv, err, ra);
    model_access(1'b0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, er, e);
    asserts++; if (lat != WAIT) begin failures++; $display("FAIL oor_wr_ready: latency %0d expected %0d", lat, WAIT); end
    access(1'b1, 1'b0, 32'h0, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h0, 32'h0, er, e);
    asserts++; if (rdv !== 32'h0BADF00D) begin failures++; $display("FAIL oor_wr_word0: got %h expected 0badf00d", rdv); end
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h10, 32'h0, er, e);
    asserts++; if (rdv !== er) begin failures++; $display("FAIL oor_wr_word4: got %h expected %h", rdv, er); end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [MW-1:0] rdv, er; logic err, ra, e;
    bit saw_ready;
    access(1'b0, 1'b1, 32'h08, 32'h11111111, lat, rdv, err, ra);
    model_access(1'b0, 1'b1, 32'h08, 32'h11111111, er, e);
    @(negedge clk);
    data_mem_write = 1'b1; dm_address = 32'h08; data_to_dm = 32'hA5A5A5A5;
    @(posedge clk);            // E0: sampled
    @(posedge clk); #2;        // second BUSY cycle
    reset = 1'b1;
    data_mem_write = 1'b0;
    exp_data_m = '0;
    #1;
    asserts++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL abort_ready: got %b expected 0", dm_ready); end
    asserts++; if (dm_data !== '0) begin failures++; $display("FAIL abort_dm_data: got %h expected 0", dm_data); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < WAIT + 4; i++) begin
      @(posedge clk); #1;
      if (dm_ready) saw_ready = 1'b1;
    end
    asserts++; if (saw_ready) begin failures++; $display("FAIL abort_no_pulse: got pulse expected none"); end
    access(1'b1, 1'b0, 32'h08, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h08, 32'h0, er, e);
    asserts++; if (rdv !== 32'h11111111) begin failures++; $display("FAIL abort_old_value: got %h expected 11111111", rdv); end
  endtask

  task automatic test_align();
    int lat; logic [MW-1:0] rdv, er; logic err, ra, e;
    access(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, lat, rdv, err, ra);
    model_access(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, er, e);
    asserts++; if (lat != WAIT) begin failures++; $display("FAIL align_wr_latency: got %0d expected %0d", lat, WAIT); end
    asserts++; if (err !== e) begin failures++; $display("FAIL align_wr_error: got %b expected %b", err, e); end
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h10, 32'h0, er, e);
    asserts++; if (rdv !== er) begin failures++; $display("FAIL align_word10: got %h expected %h", rdv, er); end
    access(1'b1, 1'b0, 32'h12, 32'h0, lat, rdv, err, ra);
    model_access(1'b1, 1'b0, 32'h12, 32'h0, er, e);
    asserts++; if (rdv !== er || err !== e) begin failures++; $display("FAIL align_rd: got %h/%b expected %h/%b", rdv, err, er, e); end
  endtask

  task automatic test_back_to_back();
    int pos [$];
    int k;
    logic [MW-1:0] er; logic e;
    model_access(1'b1, 1'b0, 32'h10, 32'h0, er, e);
    @(negedge clk);
    data_mem_read = 1'b1; dm_address = 32'h10;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dm_ready) begin
        pos.push_back(i);
        asserts++; if (dm_data !== er) begin failures++; $display("FAIL b2b_data: got %h expected %h", dm_data, er); end
      end
    end
    data_mem_read = 1'b0;
    k = 0;
    for (int p = WAIT; p < 20; p += WAIT + 2) k++;
    asserts++; if (pos.size() != k) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", pos.size(), k); end
    for (int j = 0; j < pos.size() && j < k; j++) begin
      asserts++;
      if (pos[j] != WAIT + j * (WAIT + 2)) begin
        failures++; $display("FAIL b2b_spacing: pulse %0d at %0d expected %0d", j, pos[j], WAIT + j * (WAIT + 2));
      end
    end
    repeat (WAIT + 3) @(posedge clk);
  endtask

  task automatic test_random();
    int lat; logic [MW-1:0] rdv, er, a, d; logic err, ra, e, r, w;
    int kind, rw;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      access(1'b0, 1'b1, 32'(i * 4), d, lat, rdv, err, ra);
      model_access(1'b0, 1'b1, 32'(i * 4), d, er, e);
    end
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 31) * 4);
      if (kind == 0) a = 32'(4 * DEPTH + $urandom_range(0, 1000) * 4);
      else if (kind == 1) a = a + 32'($urandom_range(1, 3));
      rw = $urandom_range(1, 3);
      r = rw[0]; w = rw[1];
      d = $urandom;
      access(r, w, a, d, lat, rdv, err, ra);
      model_access(r, w, a, d, er, e);
      asserts++; if (lat != WAIT) begin failures++; $display("FAIL rnd_latency: op %0d got %0d expected %0d", n, lat, WAIT); end
      asserts++; if (ra !== 1'b0) begin failures++; $display("FAIL rnd_pulse: op %0d ready %b expected 0", n, ra); end
      asserts++; if (rdv !== er) begin failures++; $display("FAIL rnd_data: op %0d addr %h got %h expected %h", n, a, rdv, er); end
      asserts++; if (err !== e) begin failures++; $display("FAIL rnd_error: op %0d addr %h got %b expected %b", n, a, err, e); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_write_both();
    test_out_of_range();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
